rr_index_arbiter: RTL and testbench

Round-robin arbiter that selects one of N level-sensitive requesters and presents the winner as a binary index with a valid/ready handshake. It sits directly upstream of the parameterized one-hot decoder: `gnt_idx` drives the decoder's `a`, and `gnt_valid & gnt_ready` drives its `enable`. The decoder then produces the one-hot select for the granted requester.

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 37 +++
 rtl/rr_index_arbiter.sv | 88 ++++++++
 tb/tb_rr_index_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin index arbiter and its downstream decoder bench.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for n entries; a single entry still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority find: first set req bit at or after ptr, wrapping to 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter  int unsigned N    = 64,
    localparam int unsigned IDXW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic            hi_found;
    logic [IDXW-1:0] hi_idx;
    logic [IDXW-1:0] lo_idx;

    // Downward scan so the lowest qualifying index wins; the "hi" half covers ptr..N-1,
    // the "lo" fallback is the lowest set bit overall, which is the wrapped winner.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (req[IDXW'(j)]) begin
                lo_idx = IDXW'(j);
                if (j >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDXW'(j);
                end
            end
        end
        found = |req;
        idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting the winner as a binary index with valid/ready handshake.
// Optional RR_ARB_LOCK_EN adds a lock input that re-arms the scan at the accepted index.
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int unsigned N    = 64,
    localparam int unsigned IDXW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            gnt_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx
);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0] adv_ptr;
    logic            accept;
    logic            window;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;

    assign accept = (state_q == GRANT) && gnt_ready;
    assign window = (state_q == IDLE) || accept;

    // Pointer after an accepted grant; wraps explicitly so non-power-of-two N works.
    always_comb begin
        adv_ptr = (gnt_idx_q == IDXW'(N - 1)) ? '0 : gnt_idx_q + IDXW'(1);
`ifdef RR_ARB_LOCK_EN
        if (lock) begin
            adv_ptr = gnt_idx_q;
        end
`endif
    end

    // The scan sees the post-acceptance pointer so back-to-back grants stay fair.
    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr_d),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (window) begin
            state_d = pick_found ? GRANT : IDLE;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_valid = (state_q == GRANT);
        gnt_idx   = gnt_idx_q;
        if (accept) begin
            ptr_d = adv_ptr;
        end
        if (window && pick_found) begin
            gnt_idx_d = pick_idx;
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter at N=64 and N=5 (lock case when RR_ARB_LOCK_EN is defined).
module tb_rr_index_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req;
    logic        rdy;
    logic        vld;
    logic [5:0]  idx;
    logic [4:0]  req5;
    logic        rdy5;
    logic        vld5;
    logic [2:0]  idx5;
`ifdef RR_ARB_LOCK_EN
    logic        lock;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_index_arbiter #(.N(64)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_ready (rdy),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt_valid (vld),
        .gnt_idx   (idx)
    );

    rr_index_arbiter #(.N(5)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .req       (req5),
        .gnt_ready (rdy5),
`ifdef RR_ARB_LOCK_EN
        .lock      (1'b0),
`endif
        .gnt_valid (vld5),
        .gnt_idx   (idx5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int exp_idx);
        check({tag, "_vld"}, 32'(vld), 32'd1);
        check({tag, "_idx"}, 32'(idx), 32'(exp_idx));
    endtask

    initial begin
        rst  = 1'b1;
        req  = '1;
        rdy  = 1'b1;
        req5 = '0;
        rdy5 = 1'b1;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif
        // Reset held with all requests high
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_vld", 32'(vld), 32'd0);
            check("rst_idx", 32'(idx), 32'd0);
        end
        rst = 1'b0;
        step();
        expect_grant("first", 0);

        // Single requester repeatedly granted
        rst = 1'b1;
        step();
        check("rst2_vld", 32'(vld), 32'd0);
        rst = 1'b0;
        req = 64'd1 << 5;
        step();
        expect_grant("single0", 5);
        step();
        expect_grant("single1", 5);
        step();
        expect_grant("single2", 5);

        // Fairness among bits 3, 7, 60
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 60);
        step();
        expect_grant("fair0", 3);
        step();
        expect_grant("fair1", 7);
        step();
        expect_grant("fair2", 60);
        step();
        expect_grant("fair3", 3);
        step();
        expect_grant("fair4", 7);

        // Backpressure: grant 7 held while req changes, then 2
        rdy = 1'b0;
        req = 64'd1 << 2;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_grant("hold", 7);
        end
        rdy = 1'b1;
        step();
        expect_grant("after_hold", 2);

        // Wrap at N=64, and N=5 sequence 1,4,1,4
        req  = 64'd1 << 63;
        req5 = 5'b10010;
        step();
        expect_grant("to63", 63);
        check("n5_0", 32'(idx5), 32'd1);
        check("n5_0_vld", 32'(vld5), 32'd1);
        req = (64'd1 << 63) | 64'd1;
        step();
        expect_grant("wrap0", 0);
        check("n5_1", 32'(idx5), 32'd4);
        step();
        expect_grant("wrap1", 63);
        check("n5_2", 32'(idx5), 32'd1);
        step();
        check("n5_3", 32'(idx5), 32'd4);

        // Requests vanish on acceptance: valid drops, index holds
        req  = '0;
        req5 = '0;
        step();
        check("idle_vld", 32'(vld), 32'd0);
        check("idle_idx", 32'(idx), 32'd0);
        check("n5_idle_vld", 32'(vld5), 32'd0);
        step();
        check("idle2_vld", 32'(vld), 32'd0);

`ifdef RR_ARB_LOCK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = (64'd1 << 2) | (64'd1 << 9);
        step();
        expect_grant("lock0", 2);
        lock = 1'b1;
        step();
        expect_grant("lock1", 2);
        lock = 1'b0;
        step();
        expect_grant("lock2", 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
